sram_ctrl: RTL and testbench

Initiator side of the external 16-bit SRAM bus. Accepts 32-bit word read/write requests from the pipeline MEM stage and performs each as two 16-bit SRAM accesses: low half, then high half. A fixed wait period follows the accesses. A combinational `ready` freezes the pipeline until the transaction completes. The block connects directly to the SRAM model / board SRAM pins.

---
 rtl/sram_ctrl.sv | 140 ++++++++++++++
 tb/tb_sram_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// 32-bit word initiator for a 16-bit asynchronous SRAM: each request becomes a low then a high halfword access, followed by a fixed wait.
// Optional address fault check is compiled in with `define SRAM_CTRL_ADDR_CHECK_EN.
module sram_ctrl #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 3,
    parameter int unsigned MEM_WORDS   = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        addr_err,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ACC_LO = 3'd1;
    localparam logic [2:0] S_ACC_HI = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

    logic [2:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_read_data;
    logic        r_wr;
    logic [16:0] r_word;
    logic [31:0] r_wdata;

    logic        w_req;
    logic        w_fault;
    logic [31:0] w_off;
    logic        w_acc_lo;
    logic        w_acc_hi;
    logic        w_drive;
    logic        w_unused;

    assign w_req = wr_en | rd_en;
    assign w_off = address - BASE_ADDR;
    // Only the word index of the offset matters; the halfword select comes from the access phase.
    assign w_unused = ^{w_off[31:19], w_off[1:0]};

`ifdef SRAM_CTRL_ADDR_CHECK_EN
    localparam logic [32:0] LIMIT_ADDR = 33'(BASE_ADDR) + 33'(4 * MEM_WORDS);
    logic r_addr_err;

    assign w_fault  = (address[1:0] != 2'b00) | (address < BASE_ADDR) | ({1'b0, address} >= LIMIT_ADDR);
    assign addr_err = r_addr_err;
`else
    assign w_fault  = 1'b0;
    assign addr_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_read_data <= 32'd0;
`ifdef SRAM_CTRL_ADDR_CHECK_EN
            r_addr_err  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (w_fault) begin
                            r_state <= S_DONE;
`ifdef SRAM_CTRL_ADDR_CHECK_EN
                            r_addr_err <= 1'b1;
`endif
                        end else begin
                            r_state <= S_ACC_LO;
                        end
                    end
                end
                S_ACC_LO: begin
                    if (!r_wr) r_read_data[15:0] <= SRAM_DQ;
                    r_state <= S_ACC_HI;
                end
                S_ACC_HI: begin
                    if (!r_wr) r_read_data[31:16] <= SRAM_DQ;
                    r_cnt   <= 4'd0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == WAIT_LAST) begin
                        r_cnt   <= 4'd0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
`ifdef SRAM_CTRL_ADDR_CHECK_EN
                    r_addr_err <= 1'b0;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Request payload is only consumed while in an access state, so it needs no reset.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && w_req) begin
            r_wr    <= wr_en;
            r_word  <= w_off[18:2];
            r_wdata <= write_data;
        end
    end

    assign w_acc_lo = (r_state == S_ACC_LO);
    assign w_acc_hi = (r_state == S_ACC_HI);
    assign w_drive  = (w_acc_lo | w_acc_hi) & r_wr;

    assign SRAM_ADDR = (w_acc_lo | w_acc_hi) ? {r_word, w_acc_hi} : 18'd0;
    assign SRAM_WE_N = ~w_drive;
    assign SRAM_DQ   = w_drive ? (w_acc_hi ? r_wdata[31:16] : r_wdata[15:0]) : 16'hzzzz;

    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

    assign read_data = r_read_data;
    assign ready     = ((r_state == S_IDLE) & ~w_req) | (r_state == S_DONE);

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl with a behavioural SRAM on the DQ bus.
module tb_sram_ctrl;

    localparam int unsigned BASE = 1024;
    localparam int unsigned W    = 3;

`ifdef SRAM_CTRL_ADDR_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] address = 32'd0;
    logic [31:0] write_data = 32'd0;
    logic [31:0] read_data;
    logic        ready;
    logic        addr_err;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic        sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n;

    logic [15:0] mem [0:511];
    logic [31:0] sh  [0:255];
    logic [31:0] last_rd;
    logic [31:0] exp_q [$];
    int          n_chk = 0;
    int          n_pass = 0;

    sram_ctrl #(.BASE_ADDR(BASE), .WAIT_CYCLES(W), .MEM_WORDS(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .addr_err   (addr_err),
        .SRAM_DQ    (sram_dq),
        .SRAM_ADDR  (sram_addr),
        .SRAM_WE_N  (sram_we_n),
        .SRAM_UB_N  (sram_ub_n),
        .SRAM_LB_N  (sram_lb_n),
        .SRAM_CE_N  (sram_ce_n),
        .SRAM_OE_N  (sram_oe_n)
    );

    always #5 clk = ~clk;

    // SRAM model: drives the bus whenever not being written.
    assign sram_dq = sram_we_n ? mem[sram_addr[8:0]] : 16'hzzzz;
    always @(posedge clk) if (!sram_we_n) mem[sram_addr[8:0]] <= sram_dq;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    // Caller sits just after a negedge. b2b: the DUT is in DONE now, so cycle 0 is the next cycle.
    task automatic run(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                       input bit b2b, input bit hold);
        int c = 0;
        int we = 0;
        int wd;
        bit fault;
        logic [31:0] e;
        logic [15:0] lo0, hi0;
        fault = CHK_EN && ((a[1:0] != 2'b00) || (a < BASE) || (a >= BASE + 128));
        wd  = int'((a - BASE) >> 2) & 255;
        lo0 = mem[2*wd];
        hi0 = mem[2*wd+1];
        wr_en = w; rd_en = r; address = a; write_data = d;
        if (fault || w) e = last_rd;
        else e = sh[wd];
        if (!fault && w) sh[wd] = d;
        last_rd = e;
        exp_q.push_back(e);
        if (b2b) @(negedge clk);
        #1;
        while (!ready && c < 40) begin
            if (!sram_we_n) we++;
            @(negedge clk); #1;
            c++;
        end
        check("latency", c, fault ? 1 : 3 + W);
        check("we_cycles", we, (w && !fault) ? 2 : 0);
        check("addr_err", {31'd0, addr_err}, {31'd0, fault});
        check("read_data", read_data, exp_q.pop_front());
        if (w && !fault) begin
            check("sram_lo", {16'd0, mem[2*wd]},   {16'd0, d[15:0]});
            check("sram_hi", {16'd0, mem[2*wd+1]}, {16'd0, d[31:16]});
        end else begin
            check("sram_lo_keep", {16'd0, mem[2*wd]},   {16'd0, lo0});
            check("sram_hi_keep", {16'd0, mem[2*wd+1]}, {16'd0, hi0});
        end
        if (!hold) begin
            wr_en = 1'b0; rd_en = 1'b0;
            @(negedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
        for (int i = 0; i < 256; i++) sh[i] = 32'h0;
        last_rd = 32'h0;

        #2;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_read_data", read_data, 32'd0);
        check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
        check("rst_addr", {14'd0, sram_addr}, 32'd0);
        check("rst_addr_err", {31'd0, addr_err}, 32'd0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); #1;

        run(1'b1, 1'b0, 32'd1024, 32'h12345678, 1'b0, 1'b0);
        run(1'b0, 1'b1, 32'd1024, 32'h0,        1'b0, 1'b0);
        run(1'b1, 1'b0, 32'd1032, 32'hCAFEF00D, 1'b0, 1'b1);
        run(1'b0, 1'b1, 32'd1032, 32'h0,        1'b1, 1'b0);
        run(1'b1, 1'b1, 32'd1028, 32'hA5A55A5A, 1'b0, 1'b0);

        // Reset asserted during the high-half access of a write.
        wr_en = 1'b1; address = 32'd1040; write_data = 32'hDEADBEEF;
        @(negedge clk); @(negedge clk); #1;
        check("acc_hi_addr", {14'd0, sram_addr}, 32'd9);
        rst = 1'b0; #1;
        check("mid_rst_we_n", {31'd0, sram_we_n}, 32'd1);
        check("mid_rst_addr", {14'd0, sram_addr}, 32'd0);
        check("mid_rst_ready_req", {31'd0, ready}, 32'd0);
        check("mid_rst_read_data", read_data, 32'd0);
        wr_en = 1'b0; #1;
        check("mid_rst_ready_idle", {31'd0, ready}, 32'd1);
        @(negedge clk); #1;
        check("partial_lo", {16'd0, mem[8]}, 32'h0000BEEF);
        check("partial_hi", {16'd0, mem[9]}, 32'h0);
        rst = 1'b1; last_rd = 32'h0;
        @(negedge clk); #1;
        run(1'b1, 1'b0, 32'd1040, 32'h0BADF00D, 1'b0, 1'b0);
        run(1'b0, 1'b1, 32'd1040, 32'h0,        1'b0, 1'b0);

        // Misaligned and past-the-end writes: faults only when the check is compiled in.
        run(1'b1, 1'b0, 32'd1026,        32'h11112222, 1'b0, 1'b0);
        run(1'b1, 1'b0, 32'd1024 + 128,  32'h33334444, 1'b0, 1'b0);
        run(1'b0, 1'b1, 32'd1024,        32'h0,        1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
